// File: rtl/fifo9_pkg.sv
// Shared constants and types for the 9-bit receive FIFO frame checker
// and the CRC-32 byte engine.
package fifo9_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int FCS_LEN   = 4;
    // One extra slot so a byte is only released once four newer bytes exist behind it
    localparam int DLY_DEPTH = FCS_LEN + 1;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update over one byte, LSB first.
// Shared with the TX FCS generator.
module crc32_d8
    import fifo9_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_out = {1'b0, crc_out[31:1]} ^ ((crc_out[0] ^ d[i]) ? CRC32_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/fifo9_frame_check.sv
// Drains the GMII receive FIFO, strips the FCS, checks CRC and length and
// emits sof/eof-framed bytes. Optional counters under FIFO9_FRAME_STATS_EN.
module fifo9_frame_check
    import fifo9_pkg::*;
#(
    parameter logic [10:0] MinLen = 11'd64,
    parameter logic [10:0] MaxLen = 11'd1518
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [8:0]  dout,
    input  logic        empty,
    output logic        rd_en,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_err
`ifdef FIFO9_FRAME_STATS_EN
    ,
    output logic [31:0] stat_good,
    output logic [31:0] stat_bad,
    output logic [15:0] stat_drop
`endif
);

    state_t      state;
    logic        rd_q;
    logic [7:0]  dly [DLY_DEPTH];
    logic [2:0]  fill;
    logic [31:0] crc;
    logic [31:0] crc_base;
    logic [31:0] crc_next;
    logic [10:0] len;
    logic        emitted;
    logic        word_ctl;
    logic [7:0]  word_byte;
    logic        dly_full;
    logic        frame_bad;

    assign rd_en     = !empty;
    assign word_ctl  = dout[8];
    assign word_byte = dout[7:0];
    assign dly_full  = (fill == 3'(DLY_DEPTH));
    assign crc_base  = (state == IDLE) ? CRC32_INIT : crc;
    // The residue over payload plus FCS is constant for any good frame
    assign frame_bad = (crc != CRC32_RESIDUE) || (len < MinLen) || (len > MaxLen);

    crc32_d8 u_crc (
        .crc_in  (crc_base),
        .d       (word_byte),
        .crc_out (crc_next)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= rd_en & !empty;
        end
    end

    // dly[0] holds the newest byte; once full, dly[DLY_DEPTH-1] is the oldest
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            fill      <= 3'd0;
            crc       <= CRC32_INIT;
            len       <= 11'd0;
            emitted   <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_err   <= 1'b0;
            for (int i = 0; i < DLY_DEPTH; i++) begin
                dly[i] <= 8'h00;
            end
        end else begin
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_err   <= 1'b0;
            if (rd_q) begin
                case (state)
                    IDLE: begin
                        if (word_ctl) begin
                            dly[0]  <= word_byte;
                            fill    <= 3'd1;
                            crc     <= crc_next;
                            len     <= 11'd1;
                            emitted <= 1'b0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        if (word_ctl) begin
                            for (int i = 1; i < DLY_DEPTH; i++) begin
                                dly[i] <= dly[i-1];
                            end
                            dly[0] <= word_byte;
                            crc    <= crc_next;
                            if (len != 11'h7FF) begin
                                len <= len + 11'd1;
                            end
                            if (dly_full) begin
                                out_valid <= 1'b1;
                                out_data  <= dly[DLY_DEPTH-1];
                                out_sof   <= !emitted;
                                emitted   <= 1'b1;
                            end else begin
                                fill <= fill + 3'd1;
                            end
                        end else begin
                            // Short frames never filled the line and vanish without an eof
                            if (dly_full) begin
                                out_valid <= 1'b1;
                                out_data  <= dly[DLY_DEPTH-1];
                                out_sof   <= !emitted;
                                out_eof   <= 1'b1;
                                out_err   <= frame_bad;
                            end
                            fill    <= 3'd0;
                            crc     <= CRC32_INIT;
                            len     <= 11'd0;
                            emitted <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef FIFO9_FRAME_STATS_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stat_good <= 32'd0;
            stat_bad  <= 32'd0;
            stat_drop <= 16'd0;
        end else if (rd_q && (state == DATA) && !word_ctl) begin
            if (!dly_full) begin
                stat_drop <= stat_drop + 16'd1;
            end else if (frame_bad) begin
                stat_bad <= stat_bad + 32'd1;
            end else begin
                stat_good <= stat_good + 32'd1;
            end
        end
    end
`endif

endmodule
